// File: rtl/cache_defs.sv
// Shared data-cache definitions: bridge FSM states and default line/bus widths.
package cache_defs;

    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DMEM_BUS_WIDTH    = 32;

    typedef enum logic [1:0] {
        DCB_IDLE  = 2'd0,
        DCB_BEAT  = 2'd1,
        DCB_DONE  = 2'd2,
        DCB_DRAIN = 2'd3
    } type_dcache_bridge_states_e;

endpackage

// File: rtl/dcache_mem_bridge.sv
// Splits one whole-line dcache read/write into BEATS word transfers on a req/ack
// memory bus and returns a single ack (plus the assembled line for reads).
module dcache_mem_bridge
    import cache_defs::*;
#(
    parameter int LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int BUS_WIDTH  = DMEM_BUS_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic                  dcache2mem_kill_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_wdata_i,
    output logic                  mem2dcache_ack_o,
    output logic [LINE_WIDTH-1:0] mem2dcache_rdata_o,
    output logic                  bridge2mem_req_o,
    output logic                  bridge2mem_we_o,
    output logic [ADDR_WIDTH-1:0] bridge2mem_addr_o,
    output logic [BUS_WIDTH-1:0]  bridge2mem_wdata_o,
    input  logic                  mem2bridge_ack_i,
    input  logic [BUS_WIDTH-1:0]  mem2bridge_rdata_i
);

    localparam int BEATS     = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_BITS = $clog2(BEATS);
    localparam int OFFS_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W     = (BEAT_BITS > 0) ? BEAT_BITS : 1;
    localparam int BUS_BYTES = BUS_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS_BITS) - 1);

    type_dcache_bridge_states_e state_q;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  wr_q;
    logic [LINE_WIDTH-1:0] wline_q;
    logic [LINE_WIDTH-1:0] line_q;

    logic last_beat;
    logic busy;

    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    // DRAIN keeps the bus request exactly as it was until memory acks it.
    assign busy      = (state_q == DCB_BEAT) || (state_q == DCB_DRAIN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= DCB_IDLE;
            beat_cnt_q <= '0;
            base_q     <= '0;
            wr_q       <= 1'b0;
            wline_q    <= '0;
            line_q     <= '0;
        end else begin
            case (state_q)
                DCB_IDLE: begin
                    if (dcache2mem_req_i && !dcache2mem_kill_i) begin
                        base_q     <= dcache2mem_addr_i & ~OFFS_MASK;
                        wr_q       <= dcache2mem_wr_i;
                        wline_q    <= dcache2mem_wdata_i;
                        beat_cnt_q <= '0;
                        state_q    <= DCB_BEAT;
                    end
                end
                DCB_BEAT: begin
                    if (mem2bridge_ack_i) begin
                        if (dcache2mem_kill_i) begin
                            state_q <= DCB_IDLE;
                        end else begin
                            if (!wr_q)
                                line_q[beat_cnt_q*BUS_WIDTH +: BUS_WIDTH] <= mem2bridge_rdata_i;
                            if (last_beat)
                                state_q <= DCB_DONE;
                            else
                                beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end else if (dcache2mem_kill_i) begin
                        state_q <= DCB_DRAIN;
                    end
                end
                DCB_DONE: begin
                    state_q <= DCB_IDLE;
                end
                DCB_DRAIN: begin
                    if (mem2bridge_ack_i)
                        state_q <= DCB_IDLE;
                end
                default: state_q <= DCB_IDLE;
            endcase
        end
    end

    assign bridge2mem_req_o   = busy;
    assign bridge2mem_we_o    = busy & wr_q;
    assign bridge2mem_addr_o  = busy ? base_q + ADDR_WIDTH'(beat_cnt_q) * ADDR_WIDTH'(BUS_BYTES) : '0;
    assign bridge2mem_wdata_o = busy ? wline_q[beat_cnt_q*BUS_WIDTH +: BUS_WIDTH] : '0;
    // A kill landing in the DONE cycle swallows the completion.
    assign mem2dcache_ack_o   = (state_q == DCB_DONE) && !dcache2mem_kill_i;
    assign mem2dcache_rdata_o = line_q;

endmodule

// File: doc/dcache_mem_bridge.md
# dcache_mem_bridge

Line-to-beat bridge between the write-back data cache controller and the word-wide data memory bus. Accepts one whole-line read (allocate) or write (write-back) request from the cache, splits it into `BEATS` sequential word transfers on a req/ack memory bus, and returns a single ack pulse. For reads, it also returns the assembled line. It sits directly downstream of the dcache controller/datapath and consumes its `dcache2mem_*` request, write and kill signals.

## Interface
- `LINE_WIDTH`, default 128: cache line width in bits.
- `BUS_WIDTH`, default 32: memory bus data width in bits. `LINE_WIDTH` is an integer multiple of it.
- `ADDR_WIDTH`, default 32: byte address width.
- Derived, not overridable:
  - `BEATS = LINE_WIDTH/BUS_WIDTH`
  - `BEAT_BITS = $clog2(BEATS)`
  - `OFFS_BITS = $clog2(LINE_WIDTH/8)`

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `dcache2mem_req_i`, in, 1: line request. The cache holds it high until ack.
- `dcache2mem_wr_i`, in, 1: 1 = write-back, 0 = allocate read. Qualified by req.
- `dcache2mem_kill_i`, in, 1: abort any ongoing transaction.
- `dcache2mem_addr_i`, in, `ADDR_WIDTH`: line byte address.
- `dcache2mem_wdata_i`, in, `LINE_WIDTH`: dirty line to write back.
- `mem2dcache_ack_o`, out, 1: one-cycle completion pulse.
- `mem2dcache_rdata_o`, out, `LINE_WIDTH`: assembled read line. Valid while ack is high.
- `bridge2mem_req_o`, out, 1: beat request.
- `bridge2mem_we_o`, out, 1: beat write enable.
- `bridge2mem_addr_o`, out, `ADDR_WIDTH`: beat byte address.
- `bridge2mem_wdata_o`, out, `BUS_WIDTH`: beat write data.
- `mem2bridge_ack_i`, in, 1: beat ack. May arrive in the same cycle as req.
- `mem2bridge_rdata_i`, in, `BUS_WIDTH`: beat read data. Valid with ack.

## Operation
States: IDLE, BEAT, DONE, DRAIN.

- **IDLE**
  - On `req & ~kill`, the bridge latches the following and goes to BEAT:
    - `base = addr` with low `OFFS_BITS` forced to 0.
    - `wr` and the full write line.
    - `beat_cnt = 0`.
  - `kill` blocks start. Kill being high in idle is normal, because the controller drives it whenever dmem is unselected.
- **BEAT**
  - `bridge2mem_req_o = 1`.
  - `bridge2mem_we_o = wr`.
  - `bridge2mem_addr_o = base + beat_cnt*(BUS_WIDTH/8)`.
  - `bridge2mem_wdata_o = wline[beat_cnt*BUS_WIDTH +: BUS_WIDTH]`.
  - On `mem2bridge_ack_i`:
    - For a read, capture `rdata` into line slice `beat_cnt`.
    - If `beat_cnt == BEATS-1`, go to DONE. Otherwise increment `beat_cnt`; req stays high for the next beat without a gap.
- **DONE**
  - `mem2dcache_ack_o = 1` for exactly this cycle. Go to IDLE.
  - Request input is not sampled in DONE, so a held req cannot retrigger.
- **DRAIN**
  - Entered on kill while a beat is outstanding.
  - Hold req/we/addr/wdata unchanged until `mem2bridge_ack_i`, then go to IDLE.
  - Discard the beat data. No cache ack is issued.
  - Memory bus rule: a req, once raised, is never withdrawn before its ack.

Kill priority:
- In BEAT with kill:
  - Ack present in the same cycle: go to IDLE.
  - No ack: go to DRAIN.
- In DONE with kill: suppress `mem2dcache_ack_o`, go to IDLE.
- Kill in DRAIN has no extra effect.

`mem2dcache_rdata_o` is driven from the line buffer. It holds its value until the next read beat overwrites it. The buffer is not cleared on write-backs.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `beat_cnt` 0, line and address registers 0.
- Asynchronous reset mid-transaction drops `bridge2mem_req_o` immediately. The memory is reset in the same domain.
- Latency with zero-wait memory (ack in the same cycle as req):
  - Request sampled at cycle 0.
  - Beats occur in cycles 1..BEATS.
  - Ack in cycle BEATS+1 (cycle 5 for defaults).
- Each memory wait state adds one cycle.
- The cache sees ack one cycle after the last beat ack, because it is registered by state.
- Back-to-back (write-back followed by allocate): the controller re-asserts req the cycle after ack. The bridge is in IDLE then and starts the new request with no bubble beyond the DONE cycle.
- Address arithmetic is modulo `2^ADDR_WIDTH`. Beats never cross the line since base is aligned.

## Structure
- Add to the shared `cache_defs` package:
  - `type_dcache_bridge_states_e` (IDLE/BEAT/DONE/DRAIN).
  - `DCACHE_LINE_WIDTH`, `DMEM_BUS_WIDTH`.
- Single module, no sub-module. The line buffer and beat counter are inline registers.

## Test plan
- **Allocate, zero-wait:** req=1, wr=0, addr=0x8000_0014; memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 on its 4 beats.
  - Beat addresses are 0x8000_0010, 0x8000_0014, 0x8000_0018, 0x8000_001C.
  - Ack occurs at cycle 5.
  - `rdata_o` = 0x44444444_33333333_22222222_11111111.
- **Write-back with 2 wait states per beat:** wdata = 0xDDDD…_AAAA….
  - `we=1`, and the beat words go out low slice first.
  - Ack occurs at cycle 13.
- **Write-back then allocate, req held continuously:** exactly two acks, one DONE cycle apart, with no spurious third transaction.
- **Kill during beat 2 while memory is stalled:** req stays high with an unchanged address until the beat ack, then drops. No `mem2dcache_ack_o`.
- **Kill in the DONE cycle:** ack is suppressed, and the state returns to IDLE.
- **`rst_ni` low mid-beat:** all outputs go to 0 asynchronously. After release, a fresh allocate completes normally.
